// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, drives instruction-memory requests and holds the IF/ID register.
// Tolerates multi-cycle memory latency, load-use stalls and taken-branch flushes.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_valid_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        inhibit_control_o
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
    } if_id_t;

    localparam if_id_t BUBBLE = {1'b0, NOP_INSTR, 32'h0};

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    if_id_t      ifid_q, ifid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;

    // Request is idle while a fetched word waits in the skid register.
    always_comb begin
        imem_req_o  = !rst_i && (state_q != HOLD);
        imem_addr_o = (state_q == DISCARD) ? pend_q : pc_q;
    end

    assign instr_o           = ifid_q.instr;
    assign pc_o              = ifid_q.pc;
    assign pc_plus4_o        = ifid_q.pc + 32'd4;
    assign inhibit_control_o = !ifid_q.valid;

    // Next state, PC and IF/ID selection; a flush outranks a stall.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_d       = pend_q;
        ifid_d       = ifid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        if (flush_i) begin
            ifid_d       = BUBBLE;
            skid_instr_d = '0;
            skid_pc_d    = '0;
            pc_d         = branch_target_i & ~32'd3;
            unique case (state_q)
                FETCH: begin
                    if (!imem_valid_i) begin
                        state_d = DISCARD;
                        pend_d  = pc_q;
                    end
                end
                HOLD: state_d = FETCH;
                DISCARD: begin
                    // A response landing now is the one being
                    // waited for; waiting longer would deadlock.
                    if (imem_valid_i) state_d = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (imem_valid_i) begin
                        if (stall_i) begin
                            skid_instr_d = imem_rdata_i;
                            skid_pc_d    = pc_q;
                            state_d      = HOLD;
                        end else begin
                            ifid_d = {1'b1, imem_rdata_i, pc_q};
                            pc_d   = pc_q + 32'd4;
                        end
                    end else if (!stall_i) begin
                        ifid_d = BUBBLE;
                    end
                end
                HOLD: begin
                    if (!stall_i) begin
                        ifid_d  = {1'b1, skid_instr_q, skid_pc_q};
                        pc_d    = pc_q + 32'd4;
                        state_d = FETCH;
                    end
                end
                DISCARD: begin
                    ifid_d = BUBBLE;
                    if (imem_valid_i) state_d = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end
    end

    // State registers; reset also drops any in-flight response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            pend_q       <= '0;
            ifid_q       <= BUBBLE;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            ifid_q       <= ifid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus a randomized run checked
// against an instruction-stream scoreboard.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, flush, valid;
    logic [31:0] target, rdata;
    logic        req, inh;
    logic [31:0] addr, instr, pc, pc4;

    logic        rst2, valid2, req2, inh2;
    logic [31:0] rdata2, addr2, instr2, pc2, pc42;

    int checks;
    int errors;

    bit          busy;
    int          wait_left;
    logic [31:0] busy_addr;
    logic [31:0] key;
    int          mem_lat;
    bit          rand_lat;
    int          proto_errs;

    fetch_stage dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .stall_i           (stall),
        .flush_i           (flush),
        .branch_target_i   (target),
        .imem_req_o        (req),
        .imem_addr_o       (addr),
        .imem_rdata_i      (rdata),
        .imem_valid_i      (valid),
        .instr_o           (instr),
        .pc_o              (pc),
        .pc_plus4_o        (pc4),
        .inhibit_control_o (inh)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk_i             (clk),
        .rst_i             (rst2),
        .stall_i           (1'b0),
        .flush_i           (1'b0),
        .branch_target_i   (32'h0),
        .imem_req_o        (req2),
        .imem_addr_o       (addr2),
        .imem_rdata_i      (rdata2),
        .imem_valid_i      (valid2),
        .instr_o           (instr2),
        .pc_o              (pc2),
        .pc_plus4_o        (pc42),
        .inhibit_control_o (inh2)
    );

    // Memory: one response per request after a latency, data = addr ^ key.
    task automatic mem_cycle();
        if (rst) begin
            busy  = 0;
            valid = 0;
        end else if (!req) begin
            if (busy) proto_errs++;
            busy  = 0;
            valid = 0;
        end else begin
            if (!busy) begin
                busy      = 1;
                busy_addr = addr;
                wait_left = rand_lat ? $urandom_range(0, 3) : mem_lat;
            end else if (addr !== busy_addr) begin
                proto_errs++;
            end
            if (wait_left == 0) begin
                valid = 1;
                rdata = busy_addr ^ key;
                busy  = 0;
            end else begin
                valid = 0;
                rdata = $urandom;
                wait_left--;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1; stall = 0; flush = 0; target = 0;
        valid = 0; rdata = 0; busy = 0;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; stall = 0; flush = 0;
        valid = 1; rdata = 32'hDEAD_BEEF; busy = 0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (req !== 1'b0) begin
            errors++;
            $display("FAIL reset_req got %b want 0", req);
        end
        checks++;
        if (inh !== 1'b1 || instr !== NOP || pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_ifid got inh=%b instr=%h pc=%h want 1 %h 0",
                     inh, instr, pc, NOP);
        end
        valid = 0;
    endtask

    task automatic test_zero_wait();
        logic [31:0] e;
        do_reset();
        key = 0; mem_lat = 0; rand_lat = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            checks++;
            if (req !== 1'b1 || addr !== 32'(4 * k)) begin
                errors++;
                $display("FAIL zw_addr k=%0d got %b %h want 1 %h",
                         k, req, addr, 32'(4 * k));
            end
            checks++;
            if (inh !== (k == 0)) begin
                errors++;
                $display("FAIL zw_inhibit k=%0d got %b want %b", k, inh, k == 0);
            end
            if (k > 0) begin
                e = 32'(4 * (k - 1));
                checks++;
                if (instr !== e || pc !== e || pc4 !== e + 32'd4) begin
                    errors++;
                    $display("FAIL zw_ifid k=%0d got %h %h %h want %h %h %h",
                             k, instr, pc, pc4, e, e, e + 32'd4);
                end
            end
            mem_cycle();
            @(negedge clk);
        end
    endtask

    task automatic test_latency();
        logic [31:0] ea, ei;
        bit          einh;
        do_reset();
        key = 32'h1234_0000; mem_lat = 2; rand_lat = 0;
        for (int k = 0; k < 12; k++) begin
            #1;
            ea   = 32'(4 * (k / 3));
            einh = (k == 0) || (k % 3 != 0);
            checks++;
            if (req !== 1'b1 || addr !== ea) begin
                errors++;
                $display("FAIL lat_addr k=%0d got %b %h want 1 %h", k, req, addr, ea);
            end
            checks++;
            if (inh !== einh) begin
                errors++;
                $display("FAIL lat_inhibit k=%0d got %b want %b", k, inh, einh);
            end
            if (!einh) begin
                ei = 32'(4 * (k / 3 - 1));
                checks++;
                if (instr !== (ei ^ key) || pc !== ei) begin
                    errors++;
                    $display("FAIL lat_ifid k=%0d got %h %h want %h %h",
                             k, instr, pc, ei ^ key, ei);
                end
            end
            mem_cycle();
            @(negedge clk);
        end
    endtask

    task automatic test_stall_hold();
        do_reset();
        key = 32'h00A0_0083; mem_lat = 0; rand_lat = 0;
        for (int k = 0; k < 4; k++) begin
            #1; mem_cycle(); @(negedge clk);
        end
        stall = 1;
        #1;
        checks++;
        if (req !== 1'b1 || addr !== 32'h10) begin
            errors++;
            $display("FAIL hold_pre got %b %h want 1 00000010", req, addr);
        end
        mem_cycle();
        @(negedge clk);
        #1;
        checks++;
        if (req !== 1'b0 || instr !== (32'hC ^ key) || pc !== 32'hC) begin
            errors++;
            $display("FAIL hold_stalled got req=%b %h %h want 0 %h 0000000c",
                     req, instr, pc, 32'hC ^ key);
        end
        mem_cycle();
        @(negedge clk);
        stall = 0;
        #1;
        checks++;
        if (req !== 1'b0) begin
            errors++;
            $display("FAIL hold_release_req got %b want 0", req);
        end
        mem_cycle();
        @(negedge clk);
        #1;
        checks++;
        if (instr !== 32'h00A0_0093 || pc !== 32'h10 || inh !== 1'b0) begin
            errors++;
            $display("FAIL hold_out got %h %h %b want 00a00093 00000010 0",
                     instr, pc, inh);
        end
        checks++;
        if (req !== 1'b1 || addr !== 32'h14) begin
            errors++;
            $display("FAIL hold_next got %b %h want 1 00000014", req, addr);
        end
        mem_cycle();
        @(negedge clk);
    endtask

    task automatic test_flush_discard();
        bit found;
        do_reset();
        key = 32'hCAFE_0000; mem_lat = 1; rand_lat = 0;
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            #1;
            if (req && addr === 32'h20 && !busy) found = 1;
            else begin
                mem_cycle();
                @(negedge clk);
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL discard_reach got no request want addr 00000020");
        end
        if (found) begin
            flush = 1; target = 32'h103;
            mem_cycle();
            @(negedge clk);
            flush = 0;
            #1;
            checks++;
            if (req !== 1'b1 || addr !== 32'h20 || inh !== 1'b1 || instr !== NOP) begin
                errors++;
                $display("FAIL discard_wait got %b %h %b %h want 1 00000020 1 %h",
                         req, addr, inh, instr, NOP);
            end
            mem_cycle();
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                #1;
                checks++;
                if (req !== 1'b1 || addr !== 32'h100 || inh !== 1'b1) begin
                    errors++;
                    $display("FAIL discard_redirect k=%0d got %b %h %b want 1 00000100 1",
                             k, req, addr, inh);
                end
                mem_cycle();
            end
            @(negedge clk);
            #1;
            checks++;
            if (inh !== 1'b0 || instr !== (32'h100 ^ key) || pc !== 32'h100) begin
                errors++;
                $display("FAIL discard_target got %b %h %h want 0 %h 00000100",
                         inh, instr, pc, 32'h100 ^ key);
            end
            mem_cycle();
            @(negedge clk);
        end
    endtask

    task automatic test_flush_stall();
        do_reset();
        key = 32'h0BAD_0000; mem_lat = 0; rand_lat = 0;
        for (int k = 0; k < 4; k++) begin
            #1; mem_cycle(); @(negedge clk);
        end
        stall = 1; flush = 1; target = 32'h200;
        #1;
        mem_cycle();
        @(negedge clk);
        stall = 0; flush = 0;
        #1;
        checks++;
        if (inh !== 1'b1 || instr !== NOP) begin
            errors++;
            $display("FAIL fs_bubble got %b %h want 1 %h", inh, instr, NOP);
        end
        checks++;
        if (req !== 1'b1 || addr !== 32'h200) begin
            errors++;
            $display("FAIL fs_pc got %b %h want 1 00000200", req, addr);
        end
        mem_cycle();
        @(negedge clk);
        #1;
        checks++;
        if (inh !== 1'b0 || instr !== (32'h200 ^ key) || pc !== 32'h200) begin
            errors++;
            $display("FAIL fs_target got %b %h %h want 0 %h 00000200",
                     inh, instr, pc, 32'h200 ^ key);
        end
        mem_cycle();
        @(negedge clk);
    endtask

    task automatic test_pc_wrap();
        rst2 = 1; valid2 = 0; rdata2 = 0;
        repeat (2) @(negedge clk);
        rst2 = 0;
        #1;
        checks++;
        if (req2 !== 1'b1 || addr2 !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_first got %b %h want 1 fffffffc", req2, addr2);
        end
        valid2 = req2; rdata2 = addr2;
        @(negedge clk);
        #1;
        checks++;
        if (addr2 !== 32'h0 || pc2 !== 32'hFFFF_FFFC || pc42 !== 32'h0
            || instr2 !== 32'hFFFF_FFFC || inh2 !== 1'b0) begin
            errors++;
            $display("FAIL wrap_second got addr=%h pc=%h pc4=%h instr=%h inh=%b want 0 fffffffc 0 fffffffc 0",
                     addr2, pc2, pc42, instr2, inh2);
        end
        valid2 = req2; rdata2 = addr2;
        @(negedge clk);
        #1;
        checks++;
        if (pc2 !== 32'h0 || pc42 !== 32'h4) begin
            errors++;
            $display("FAIL wrap_third got pc=%h pc4=%h want 0 4", pc2, pc42);
        end
        rst2 = 1; valid2 = 0;
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, p_target, last_instr, last_pc;
        bit          p_stall, p_flush, last_inh;
        int          delivered;
        do_reset();
        key = $urandom; rand_lat = 1; proto_errs = 0;
        exp_pc = 0; p_stall = 0; p_flush = 0; p_target = 0;
        last_instr = 0; last_pc = 0; last_inh = 0; delivered = 0;
        for (int c = 0; c < 3000; c++) begin
            #1;
            checks++;
            if (p_flush) begin
                exp_pc = p_target & ~32'd3;
                if (inh !== 1'b1 || instr !== NOP) begin
                    errors++;
                    $display("FAIL rnd_flush c=%0d got %b %h want 1 %h", c, inh, instr, NOP);
                end
            end else if (p_stall) begin
                if (inh !== last_inh || instr !== last_instr || pc !== last_pc) begin
                    errors++;
                    $display("FAIL rnd_stall c=%0d got %b %h %h want %b %h %h",
                             c, inh, instr, pc, last_inh, last_instr, last_pc);
                end
            end else if (inh === 1'b0) begin
                if (pc !== exp_pc || instr !== (exp_pc ^ key) || pc4 !== exp_pc + 32'd4) begin
                    errors++;
                    $display("FAIL rnd_instr c=%0d got %h %h %h want %h %h %h",
                             c, pc, instr, pc4, exp_pc, exp_pc ^ key, exp_pc + 32'd4);
                end
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end else if (instr !== NOP) begin
                errors++;
                $display("FAIL rnd_bubble c=%0d got %h want %h", c, instr, NOP);
            end
            last_inh = inh; last_instr = instr; last_pc = pc;
            stall  = ($urandom_range(0, 3) == 0);
            flush  = ($urandom_range(0, 11) == 0);
            target = $urandom;
            #1;
            if (req && !busy) begin
                checks++;
                if (addr !== exp_pc) begin
                    errors++;
                    $display("FAIL rnd_req c=%0d got %h want %h", c, addr, exp_pc);
                end
            end
            mem_cycle();
            p_stall = stall; p_flush = flush; p_target = target;
            @(negedge clk);
        end
        stall = 0; flush = 0;
        checks++;
        if (proto_errs != 0) begin
            errors++;
            $display("FAIL rnd_protocol got %0d violations want 0", proto_errs);
        end
        checks++;
        if (delivered < 200) begin
            errors++;
            $display("FAIL rnd_progress got %0d instrs want >=200", delivered);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1; stall = 0; flush = 0; target = 0; valid = 0; rdata = 0;
        rst2 = 1; valid2 = 0; rdata2 = 0;
        busy = 0; wait_left = 0; busy_addr = 0; key = 0;
        mem_lat = 0; rand_lat = 0; proto_errs = 0;
        @(negedge clk);
        test_reset();
        test_zero_wait();
        test_latency();
        test_stall_hold();
        test_flush_discard();
        test_flush_stall();
        test_pc_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
